jtmx5k_sdram_arb: RTL
=====================

JTMX5K_SDRAM_ARB -- requirements
Module: jtmx5k_sdram_arb

Interface
REQ-001 Parameter SLOTS, 4: number of requesters; fixed at 4 for this design.
REQ-002 Parameter AW, 22: SDRAM word-address width.
REQ-003 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port downloading, input, 1: ROM download in progress; inhibits fetches.
REQ-006 Port slot_cs, input, 4: per-slot read request.
REQ-007 Port slot_addr, input, 4x22: per-slot word address, offset already applied.
REQ-008 Port slot_ok, output, 4: slot_dout valid for the current slot_addr.
REQ-009 Port slot_dout, output, 4x16: per-slot data.
REQ-010 Port sdram_req, output, 1: SDRAM read request.
REQ-011 Port sdram_ack, input, 1: SDRAM accepted the request.
REQ-012 Port sdram_addr, output, 22: address of the granted request.
REQ-013 Port data_dst, input, 1: read data burst starting.
REQ-014 Port data_rdy, input, 1: data_read valid.
REQ-015 Port data_read, input, 16: SDRAM read data.

Function
REQ-016 Each slot SHALL hold one cache entry: valid bit, 22-bit tag, 16-bit data.
REQ-017 slot_ok[i] SHALL be combinational: slot_cs[i] & valid[i] & (slot_addr[i]==tag[i]); full 22-bit compare.
REQ-018 slot_dout[i] SHALL always equal the data[i] register.
REQ-019 A slot SHALL be pending when slot_cs=1 and slot_ok=0.
REQ-020 FSM states SHALL be IDLE, WAIT_ACK, WAIT_DST, WAIT_RDY.
REQ-021 IDLE: if downloading=0 and any slot is pending, grant one pending slot round-robin, searching from last grant+1 (mod 4); latch its index and address into sdram_addr; set sdram_req=1; go to WAIT_ACK.
REQ-022 WAIT_ACK: on sdram_ack=1, clear sdram_req on the next edge and go to WAIT_DST.
REQ-023 WAIT_DST: on data_dst=1, go to WAIT_RDY; if data_rdy=1 in the same cycle, treat it as WAIT_RDY completion.
REQ-024 WAIT_RDY: on data_rdy=1, write data_read to data[grant], set tag[grant]=latched address and valid[grant]=1, update the last-grant pointer, and return to IDLE.
REQ-025 Miss latency: sdram_req rises on the edge after the pending condition appears; slot_ok rises on the edge after data_rdy if the address is unchanged.
REQ-026 If slot_addr changes mid-fetch, the fetched data SHALL still be stored under the latched tag; slot_ok stays 0 and a new fetch is arbitrated from IDLE.
REQ-027 slot_cs falling mid-fetch SHALL NOT abort the transaction.
REQ-028 data_dst or data_rdy received in IDLE or WAIT_ACK SHALL be ignored.
REQ-029 Hits SHALL NOT generate SDRAM traffic; at most one transaction is outstanding.
REQ-030 downloading=1 SHALL clear all valid bits, drop sdram_req and force IDLE on the next edge, including mid-transaction.

Reset
REQ-031 On rst=1 (clocked): state IDLE, sdram_req=0, sdram_addr=0, all valid=0, tags=0, data=0, last-grant pointer=3 (slot 0 wins first); slot_ok therefore 0.

Structure
REQ-032 A shared package jtmx5k_arb_pkg SHALL hold the FSM state typedef and the SLOTS and AW constants.
REQ-033 The per-slot cache entry and comparator SHALL be one sub-module, jtmx5k_arb_slot, instantiated SLOTS times; the FSM and round-robin logic stay in the top module.

Verification
REQ-034 After reset, slot0 cs with addr 0x01234 -> sdram_req=1, sdram_addr=0x01234; after ack, dst, rdy with data 0xBEEF -> slot_ok[0]=1 and slot_dout[0]=0xBEEF one cycle after rdy.
REQ-035 Repeat slot0 addr 0x01234 -> slot_ok[0]=1 in the same cycle, sdram_req stays 0.
REQ-036 All four slots request simultaneously after reset -> grants in order 0,1,2,3; slot 0 re-requests a new address during the slot-1 fetch -> next grant is 2, not 0.
REQ-037 Slot2 addr changes from 0x00100 to 0x00200 between ack and rdy -> tag=0x00100 stored, slot_ok[2]=0, second fetch issued with sdram_addr=0x00200.
REQ-038 downloading pulses high in WAIT_RDY -> sdram_req=0, all slot_ok=0, state IDLE, a later data_rdy is ignored; fetches resume after downloading falls.
REQ-039 rst asserted in WAIT_DST -> all REQ-031 values on the next edge.

Source files
------------

// File: rtl/jtmx5k_arb_pkg.sv
// Shared constants and FSM state type for the SDRAM read arbiter.
package jtmx5k_arb_pkg;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned AW    = 22;
    localparam int unsigned DW    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitDst,
        StWaitRdy
    } arb_state_e;

endpackage

// File: rtl/jtmx5k_arb_slot.sv
// One-entry read cache for a single requester: valid bit, tag, data and hit compare.
module jtmx5k_arb_slot
    import jtmx5k_arb_pkg::*;
#(
    parameter int unsigned AW_W = AW,
    parameter int unsigned DW_W = DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            cs,
    input  logic [AW_W-1:0] addr,
    input  logic            wr,
    input  logic [AW_W-1:0] wr_tag,
    input  logic [DW_W-1:0] wr_data,
    output logic            ok,
    output logic            pending,
    output logic [DW_W-1:0] dout
);

    logic            valid_q, valid_d;
    logic [AW_W-1:0] tag_q, tag_d;
    logic [DW_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (wr) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
            data_d  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign ok      = cs & valid_q & (addr == tag_q);
    assign pending = cs & ~ok;
    assign dout    = data_q;

endmodule

// File: rtl/jtmx5k_sdram_arb.sv
// Round-robin SDRAM read arbiter feeding four single-entry slot caches.
module jtmx5k_sdram_arb #(
    parameter int unsigned SLOTS = jtmx5k_arb_pkg::SLOTS,
    parameter int unsigned AW    = jtmx5k_arb_pkg::AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*16-1:0] slot_dout,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic [AW-1:0]       sdram_addr,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);

    import jtmx5k_arb_pkg::*;

    localparam int unsigned GW = $clog2(SLOTS);

    arb_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;

    logic [SLOTS-1:0] pending;
    logic [SLOTS-1:0] slot_wr;
    logic             complete;
    logic             found;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    cand;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        jtmx5k_arb_slot #(
            .AW_W (AW),
            .DW_W (16)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (downloading),
            .cs      (slot_cs[i]),
            .addr    (slot_addr[i*AW +: AW]),
            .wr      (slot_wr[i]),
            .wr_tag  (addr_q),
            .wr_data (data_read),
            .ok      (slot_ok[i]),
            .pending (pending[i]),
            .dout    (slot_dout[i*16 +: 16])
        );
    end

    // A burst whose dst and rdy coincide completes straight out of WAIT_DST.
    assign complete = ~downloading & data_rdy &
                      ((state_q == StWaitRdy) | ((state_q == StWaitDst) & data_dst));

    always_comb begin
        slot_wr = '0;
        slot_wr[grant_q] = complete;
    end

    // First pending slot after the last one served.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int unsigned k = 1; k <= SLOTS; k++) begin
            cand = GW'((32'(last_q) + k) % SLOTS);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (downloading) begin
            state_d = StIdle;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_d = pick;
                        addr_d  = slot_addr[pick*AW +: AW];
                        req_d   = 1'b1;
                        state_d = StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (sdram_ack) begin
                        req_d   = 1'b0;
                        state_d = StWaitDst;
                    end
                end
                StWaitDst: begin
                    if (data_dst) begin
                        state_d = StWaitRdy;
                    end
                end
                StWaitRdy: begin
                end
                default: state_d = StIdle;
            endcase
            if (complete) begin
                last_d  = grant_q;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= '0;
            grant_q <= '0;
            last_q  <= GW'(SLOTS - 1);
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule
